alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Issuing side of the ALU operation interface. Accepts one decoded register-register instruction at a time.
//  Reads operands from the register file into latched A/B registers and drives the ALU opcode.
//  Captures Z_lo/Z_hi into Z registers, then writes back to the register file (Rc <= Ra op Rb), or to HI/LO for MUL/DIV.
//  Sits between instruction decode and the datapath; owns the operand-load/execute/writeback sequencing.
// PARAMETERS
//  DATA_W      32  datapath width (A, B, Z_lo, Z_hi, register data)
//  SEL_W       4   register-file select width (16 GPRs)
//  EXEC_CYCLES 1   cycles opcode is held on alu_op before Z capture (1..15; ALU settle time)
// PORTS
//  clock        in   1       single clock, rising edge
//  clear_n      in   1       asynchronous active-low reset
//  instr_valid  in   1       decode presents an instruction
//  instr_ready  out  1       sequencer can accept (IDLE only)
//  instr_op     in   5       opcode (encoding below)
//  instr_ra     in   SEL_W   operand A register
//  instr_rb     in   SEL_W   operand B register (ignored for NEG/NOT)
//  instr_rc     in   SEL_W   destination register
//  rf_rd_sel    out  SEL_W   register-file read select
//  rf_rd_data   in   DATA_W  register-file read data, combinational from rf_rd_sel
//  alu_a        out  DATA_W  latched operand A
//  alu_b        out  DATA_W  latched operand B
//  alu_op       out  5       ALU operation; 5'b00000 outside EXEC
//  alu_z_lo     in   DATA_W  ALU low result
//  alu_z_hi     in   DATA_W  ALU high result (MUL/DIV)
//  rf_we        out  1       GPR write strobe, one cycle
//  rf_wr_sel    out  SEL_W   GPR write select (= latched rc)
//  rf_wr_data   out  DATA_W  GPR write data (= Z_lo reg)
//  hilo_we      out  1       HI/LO write strobe, one cycle
//  hi_data      out  DATA_W  Z_hi reg
//  lo_data      out  DATA_W  Z_lo reg
//  done         out  1       one-cycle pulse, instruction retired
//  illegal      out  1       one-cycle pulse, opcode not in table
// BEHAVIOUR
//  Opcodes: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001,
//   AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. Unary: NEG, NOT.
//  Reset (async, clear_n=0): state IDLE; every register and output 0 except instr_ready=1.
//   Mid-instruction reset aborts: no rf_we/hilo_we/done; strobes drop immediately.
//  Handshake: transfer when instr_valid && instr_ready; op/ra/rb/rc latched that edge.
//   instr_ready=1 only in IDLE; inputs ignored otherwise.
//  FSM (one state per cycle unless noted):
//   IDLE  : on transfer -> ILLEGAL if op not in table, else LOAD_A.
//   LOAD_A: rf_rd_sel=ra; A <= rf_rd_data. -> LOAD_B (binary) or EXEC (unary; B <= 0).
//   LOAD_B: rf_rd_sel=rb; B <= rf_rd_data. -> EXEC.
//   EXEC  : alu_op=op for EXEC_CYCLES cycles (counter from EXEC_CYCLES-1 to 0).
//           On last cycle Z_lo <= alu_z_lo, Z_hi <= alu_z_hi. -> WB.
//   WB    : MUL/DIV: hilo_we=1; others: rf_we=1 to rc. done=1. -> IDLE.
//   ILLEGAL: illegal=1, no writes, no done. -> IDLE.
//  rf_rd_sel = 0 outside LOAD_A/LOAD_B. rf_wr_sel/rf_wr_data/hi_data/lo_data hold last values between strobes.
//  Latency (accept edge = 0): binary WB at cycle 3+EXEC_CYCLES, unary 2+EXEC_CYCLES.
//   Back-to-back: next accept no earlier than cycle after WB.
//  Z_hi captured for all ops but used only by MUL/DIV; rc=ra or rc=rb legal (operands already latched).
// TESTING
//  T1 ADD R1=5,R2=7 -> R3; EXEC_CYCLES=1 -> rf_we at cycle 4, rf_wr_sel=3, rf_wr_data=12, done same cycle.
//  T2 MUL A=32'h0001_0000, B=32'h0001_0000 -> hilo_we once, hi_data=1, lo_data=0, rf_we never set.
//  T3 NEG R4=1 -> R4: no LOAD_B state visited, rf_wr_data=32'hFFFF_FFFF at cycle 3, alu_b=0 during EXEC.
//  T4 op 5'b11111 -> illegal pulse at cycle 1, no rf_we/hilo_we/done, instr_ready back to 1 at cycle 2.
//  T5 instr_valid held high with 3 queued ADDs -> exactly one accept per ready window; 3 done pulses, in order.
//  T6 clear_n low during EXEC (EXEC_CYCLES=4) -> outputs 0 asynchronously, no writeback, next ADD completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one register-register instruction through operand load, ALU execute and writeback.
module alu_op_sequencer #(
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_op,
  input  logic [SEL_W-1:0]  instr_ra,
  input  logic [SEL_W-1:0]  instr_rb,
  input  logic [SEL_W-1:0]  instr_rc,
  output logic [SEL_W-1:0]  rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_z_lo,
  input  logic [DATA_W-1:0] alu_z_hi,
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_wr_sel,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  output logic              done,
  output logic              illegal
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WB, ILL} state_t;
  state_t            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [SEL_W-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, wsel_q, wsel_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, zlo_q, zlo_d, zhi_q, zhi_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              legal, unary, muldiv;
  assign legal  = (instr_op >= 5'd3 && instr_op <= 5'd11) || (instr_op >= 5'd15 && instr_op <= 5'd18);
  assign unary  = op_q == 5'd17 || op_q == 5'd18;
  assign muldiv = op_q == 5'd15 || op_q == 5'd16;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    wsel_d  = wsel_q;
    a_d     = a_q;
    b_d     = b_q;
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        op_d    = instr_op;
        ra_d    = instr_ra;
        rb_d    = instr_rb;
        rc_d    = instr_rc;
        state_d = legal ? LOAD_A : ILL;
      end
      LOAD_A: begin
        a_d     = rf_rd_data;
        b_d     = unary ? '0 : b_q;
        cnt_d   = 4'(EXEC_CYCLES - 1);
        state_d = unary ? EXEC : LOAD_B;
      end
      LOAD_B: begin
        b_d     = rf_rd_data;
        cnt_d   = 4'(EXEC_CYCLES - 1);
        state_d = EXEC;
      end
      EXEC: if (cnt_q == '0) begin
        zlo_d   = alu_z_lo;
        zhi_d   = alu_z_hi;
        wsel_d  = rc_q;
        state_d = WB;
      end else begin
        cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      wsel_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zlo_q   <= '0;
      zhi_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      wsel_q  <= wsel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      cnt_q   <= cnt_d;
    end
  end
  // Strobes decode straight from state so an async clear drops them at once
  assign instr_ready = state_q == IDLE;
  assign rf_rd_sel   = state_q == LOAD_A ? ra_q : state_q == LOAD_B ? rb_q : '0;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = state_q == EXEC ? op_q : 5'd0;
  assign rf_we       = state_q == WB && !muldiv;
  assign hilo_we     = state_q == WB && muldiv;
  assign done        = state_q == WB;
  assign illegal     = state_q == ILL;
  assign rf_wr_sel   = wsel_q;
  assign rf_wr_data  = zlo_q;
  assign lo_data     = zlo_q;
  assign hi_data     = zhi_q;
endmodule
